// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the pipeline WB stage
// and a long-latency unit (mul/div). Long-latency results that cannot be
// written immediately wait in a 2-entry FIFO. Normally the pipeline has
// priority. If the FIFO head has waited STARVE_LIMIT cycles, the pipeline is
// stalled for one cycle so that the head can drain.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   pl_valid/rd/data    pipeline write request
//   pl_stall            pipeline must hold WB and re-present pl_* next cycle
//   lu_valid/rd/data    long-latency result offer
//   lu_ready            a long-latency result can be accepted this cycle
//   rf_we/rd/wdata      registered register-file write port
//   fifo_count          number of queued long-latency results (0..2)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pl_valid,
    input  logic [4:0]  pl_rd,
    input  logic [31:0] pl_data,
    output logic        pl_stall,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic [1:0]  fifo_count
);

    localparam logic [2:0] AGE_LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_PL,
        GRANT_HEAD,
        GRANT_BYPASS
    } grant_t;

    // FIFO storage: head is the oldest entry, tail the second one.
    logic [4:0]  head_rd, tail_rd;
    logic [31:0] head_data, tail_data;
    logic [1:0]  count_q;
    logic [2:0]  age_q;

    grant_t      grant;
    logic        pl_eff;
    logic        lu_keep;
    logic        fifo_empty;
    logic        pop;
    logic        push;
    logic [1:0]  count_after_pop;
    logic [1:0]  count_next;
    logic [2:0]  age_next;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;

    // Both handshake outputs come from registered state only.
    assign pl_stall   = (age_q == AGE_LIMIT);
    assign lu_ready   = (count_q != 2'd2);
    assign fifo_count = count_q;

    assign fifo_empty = (count_q == 2'd0);
    assign pl_eff     = pl_valid && (pl_rd != 5'd0) && !pl_stall;
    // Results aimed at x0 are accepted but dropped.
    assign lu_keep    = lu_valid && lu_ready && (lu_rd != 5'd0);

    always_comb begin
        grant = GRANT_NONE;
        if (pl_stall && !fifo_empty) begin
            grant = GRANT_HEAD;
        end else if (pl_eff) begin
            grant = GRANT_PL;
        end else if (!fifo_empty) begin
            grant = GRANT_HEAD;
        end else if (lu_keep) begin
            grant = GRANT_BYPASS;
        end
    end

    assign pop             = (grant == GRANT_HEAD);
    assign push            = lu_keep && (grant != GRANT_BYPASS);
    assign count_after_pop = count_q - {1'b0, pop};
    assign count_next      = count_after_pop + {1'b0, push};

    always_comb begin
        wr_rd   = 5'd0;
        wr_data = 32'd0;
        case (grant)
            GRANT_PL: begin
                wr_rd   = pl_rd;
                wr_data = pl_data;
            end
            GRANT_HEAD: begin
                wr_rd   = head_rd;
                wr_data = head_data;
            end
            GRANT_BYPASS: begin
                wr_rd   = lu_rd;
                wr_data = lu_data;
            end
            default: begin
                wr_rd   = 5'd0;
                wr_data = 32'd0;
            end
        endcase
    end

    // The age counter tracks only an entry that already sat at the head at
    // the start of the cycle. An entry pushed into an empty FIFO starts at 0.
    always_comb begin
        age_next = age_q;
        if (pop || (count_next == 2'd0)) begin
            age_next = 3'd0;
        end else if (!fifo_empty && (age_q != AGE_LIMIT)) begin
            age_next = age_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we     <= 1'b0;
            rf_rd     <= 5'd0;
            rf_wdata  <= 32'd0;
            count_q   <= 2'd0;
            age_q     <= 3'd0;
            head_rd   <= 5'd0;
            head_data <= 32'd0;
            tail_rd   <= 5'd0;
            tail_data <= 32'd0;
        end else begin
            rf_we    <= (grant != GRANT_NONE);
            rf_rd    <= wr_rd;
            rf_wdata <= wr_data;
            count_q  <= count_next;
            age_q    <= age_next;

            if (pop) begin
                head_rd   <= tail_rd;
                head_data <= tail_data;
            end
            // A push lands in the first free slot after this cycle's pop. It
            // overrides the shift above when the FIFO drains to empty first.
            if (push) begin
                if (count_after_pop == 2'd0) begin
                    head_rd   <= lu_rd;
                    head_data <= lu_data;
                end else begin
                    tail_rd   <= lu_rd;
                    tail_data <= lu_data;
                end
            end
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_LIMIT, default 4, giving the number of cycles a queued long-latency result may wait before the pipeline is stalled; legal range 1..7.
REQ-002 The module SHALL have these ports:
- clk  input  1  rising-edge clock, the only clock in the module.
- rst_n  input  1  asynchronous active-low reset.
- pl_valid  input  1  register write request from the pipeline WB stage.
- pl_rd  input  5  destination register for the pipeline write.
- pl_data  input  32  write data for the pipeline write.
- pl_stall  output  1  pipeline must hold the WB stage and its pl_* inputs this cycle.
- lu_valid  input  1  result offered by the long-latency unit (mul/div).
- lu_rd  input  5  destination register for the long-latency result.
- lu_data  input  32  long-latency result data.
- lu_ready  output  1  arbiter can accept a long-latency result this cycle.
- rf_we  output  1  register-file write enable.
- rf_rd  output  5  register-file write address.
- rf_wdata  output  32  register-file write data.
- fifo_count  output  2  number of queued long-latency results, 0..2.
REQ-003 Clock and reset are decided: one clock, clk; reset rst_n, asynchronous, active-low.

Function
REQ-004 The module SHALL share the single register-file write port between the pipeline and the long-latency unit; at most one write per cycle.
REQ-005 A pipeline request is effective when pl_valid=1, pl_rd!=0 and pl_stall=0; pl_valid with pl_rd=0 SHALL be treated as no request.
REQ-006 A long-latency handshake SHALL complete when lu_valid=1 and lu_ready=1; lu_ready = (fifo_count<2), driven from registered state only.
REQ-007 An accepted long-latency result with lu_rd=0 SHALL be discarded: not queued, never written.
REQ-008 The queue SHALL be a 2-entry FIFO, oldest entry at the head.
REQ-009 Grant priority each cycle: (1) FIFO head if pl_stall=1; (2) effective pipeline request; (3) FIFO head if non-empty; (4) bypass of a result accepted this cycle, only when the FIFO is empty and there is no effective pipeline request; (5) none.
REQ-010 A bypassed result SHALL NOT enter the FIFO; fifo_count stays 0.
REQ-011 The granted write SHALL appear on rf_we/rf_rd/rf_wdata at the next rising edge (registered, 1-cycle latency); rf_we SHALL be 0 on cycles following no grant.
REQ-012 A push and a head pop in the same cycle SHALL leave fifo_count unchanged and preserve order.
REQ-013 An accepted result SHALL be pushed behind existing entries when not bypassed.
REQ-014 A 3-bit age counter SHALL count cycles the head waits ungranted, saturating at STARVE_LIMIT, and SHALL clear on every head pop and when the FIFO becomes empty.
REQ-015 pl_stall SHALL equal (age==STARVE_LIMIT), driven from registered state, and is high for exactly one cycle per starvation event because the head is granted that cycle.
REQ-016 While pl_stall=1, pl_* SHALL be ignored; the pipeline re-presents the same write on the next cycle.
REQ-017 Ordering between writes to the same rd from different sources SHALL be grant order; WAW prevention is outside this block.

Reset
REQ-018 When rst_n=0, the module SHALL asynchronously clear rf_we, rf_rd, rf_wdata, fifo_count, the age counter and the FIFO contents to 0, giving pl_stall=0 and lu_ready=1.
REQ-019 If reset asserts mid-operation, queued results SHALL be dropped with no write issued, and the first grant SHALL occur on the first edge after rst_n rises.

Verification
REQ-020 Scenario: pipeline idle, lu_valid=1, lu_rd=5, lu_data=0xDEAD0001 for one cycle -> next edge rf_we=1, rf_rd=5, rf_wdata=0xDEAD0001, and fifo_count stays 0.
REQ-021 Scenario: pl_valid=1, pl_rd=3, pl_data=0x11 together with lu result rd=7, data=0x22 -> rf writes x3=0x11; fifo_count=1; next idle cycle rf writes x7=0x22 and fifo_count=0.
REQ-022 Scenario: pipeline writes rd=1..10 every cycle; lu offers 3 results back-to-back -> lu_ready=0 after 2 queued; with STARVE_LIMIT=4, pl_stall=1 exactly one cycle after the head has waited 4 cycles; the head is written that cycle; the held pipeline write is written the following cycle with none lost.
REQ-023 Scenario: lu result with lu_rd=0, and pl_valid=1 with pl_rd=0 -> rf_we stays 0 and fifo_count stays 0.
REQ-024 Scenario: FIFO holds 2 entries and a pipeline write is pending; rst_n pulsed low mid-cycle -> all outputs 0 immediately, lu_ready=1, and no write of the dropped entries after release.
